// File: rtl/arbitro_rr.sv
// arbitro_rr: drains N_IN FWFT input FIFOs into 2^DEST_W output FIFOs,
// round-robin or fixed priority, with one-slot hold-off and a word counter.
module arbitro_rr #(
    parameter int DATA_W  = 10,
    parameter int DEST_W  = 2,
    parameter int N_IN    = 4,
    parameter int RR_MODE = 1,
    parameter int CNT_W   = 16
) (
    input  logic                             clk,
    input  logic                             reset_L,
    input  logic [N_IN*DATA_W-1:0]           data_in,
    input  logic [N_IN-1:0]                  empty,
    input  logic [(2**DEST_W)-1:0]           full,
    output logic [N_IN-1:0]                  rd,
    output logic [(2**DEST_W)*DATA_W-1:0]    data_out,
    output logic [(2**DEST_W)-1:0]           wr,
    output logic [$clog2(N_IN)-1:0]          grant_id,
    output logic [DEST_W-1:0]                last_dest,
    output logic                             valid_grant,
    output logic [CNT_W-1:0]                 word_count
);

    localparam int N_OUT = 2 ** DEST_W;
    localparam int ID_W  = $clog2(N_IN);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   sel_id;
    logic [ID_W-1:0]   ptr_nxt;
    logic              sel_vld;
    logic [DEST_W-1:0] sel_dest;
    logic [N_IN-1:0]   hold_in;
    logic [N_OUT-1:0]  hold_dest;
    logic [N_IN-1:0]   eligible;
    logic [DEST_W-1:0] dest [N_IN];

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            dest[i]     = data_in[i*DATA_W + DATA_W - 1 -: DEST_W];
            eligible[i] = !empty[i] && !hold_in[i] &&
                          !full[dest[i]] && !hold_dest[dest[i]];
        end
    end

    // Scan starts at ptr in round-robin mode, at input 0 otherwise.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = '0;
        for (int k = 0; k < N_IN; k++) begin
            int j;
            j = (RR_MODE != 0) ? int'(ptr) + k : k;
            if (j >= N_IN) j = j - N_IN;
            if (!sel_vld && eligible[j]) begin
                sel_vld = 1'b1;
                sel_id  = ID_W'(j);
            end
        end
        sel_dest = dest[sel_id];
        ptr_nxt  = (sel_id == ID_W'(N_IN - 1)) ? '0 : sel_id + ID_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            rd          <= '0;
            wr          <= '0;
            data_out    <= '0;
            grant_id    <= '0;
            last_dest   <= '0;
            valid_grant <= 1'b0;
            word_count  <= '0;
            ptr         <= '0;
            hold_in     <= '0;
            hold_dest   <= '0;
        end else begin
            rd          <= '0;
            wr          <= '0;
            valid_grant <= 1'b0;
            hold_in     <= '0;
            hold_dest   <= '0;
            if (sel_vld) begin
                rd[sel_id]   <= 1'b1;
                wr[sel_dest] <= 1'b1;
                data_out[int'(sel_dest)*DATA_W +: DATA_W]
                    <= data_in[int'(sel_id)*DATA_W +: DATA_W];
                grant_id     <= sel_id;
                last_dest    <= sel_dest;
                valid_grant  <= 1'b1;
                word_count   <= word_count + CNT_W'(1);
                // Mask both ends while the FIFOs consume this handshake.
                hold_in[sel_id]     <= 1'b1;
                hold_dest[sel_dest] <= 1'b1;
                if (RR_MODE != 0) ptr <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_rr.sv
// tb_arbitro_rr: scoreboarded bench for a round-robin and a
// fixed-priority arbitro_rr instance driven by the same FIFO heads.
module tb_arbitro_rr;

    logic        clk = 1'b0;
    logic        reset_L;
    logic [39:0] data_in;
    logic [3:0]  empty;
    logic [3:0]  full;

    logic [3:0]  rd0, wr0, rd1, wr1;
    logic [39:0] dout0, dout1;
    logic [1:0]  gid0, gid1, ld0, ld1;
    logic        vg0, vg1;
    logic [3:0]  cnt0, cnt1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    arbitro_rr #(.DATA_W(10), .DEST_W(2), .N_IN(4), .RR_MODE(1), .CNT_W(4)) u_rr (
        .clk(clk), .reset_L(reset_L), .data_in(data_in), .empty(empty),
        .full(full), .rd(rd0), .data_out(dout0), .wr(wr0), .grant_id(gid0),
        .last_dest(ld0), .valid_grant(vg0), .word_count(cnt0)
    );

    arbitro_rr #(.DATA_W(10), .DEST_W(2), .N_IN(4), .RR_MODE(0), .CNT_W(4)) u_fp (
        .clk(clk), .reset_L(reset_L), .data_in(data_in), .empty(empty),
        .full(full), .rd(rd1), .data_out(dout1), .wr(wr1), .grant_id(gid1),
        .last_dest(ld1), .valid_grant(vg1), .word_count(cnt1)
    );

    typedef struct packed {
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic [39:0] dout;
        logic [1:0]  gid;
        logic [1:0]  ld;
        logic        vg;
        logic [3:0]  cnt;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       m_st[2];
    logic [1:0] m_ptr[2];
    logic [3:0] m_hin[2];
    logic [3:0] m_hdst[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int u, input bit rr, output exp_t e);
        exp_t s;
        s = m_st[u];
        if (!reset_L) begin
            s         = '0;
            m_ptr[u]  = 2'd0;
            m_hin[u]  = 4'd0;
            m_hdst[u] = 4'd0;
        end else begin
            int         sel;
            int         start;
            logic [3:0] nh_in;
            logic [3:0] nh_d;
            logic [1:0] sd;
            sel   = -1;
            start = rr ? int'(m_ptr[u]) : 0;
            nh_in = 4'd0;
            nh_d  = 4'd0;
            s.rd  = 4'd0;
            s.wr  = 4'd0;
            s.vg  = 1'b0;
            for (int k = 0; k < 4; k++) begin
                int         i;
                logic [1:0] d;
                i = (start + k) % 4;
                d = data_in[i*10+8 +: 2];
                if (sel < 0 && !empty[i] && !m_hin[u][i] && !full[d] && !m_hdst[u][d])
                    sel = i;
            end
            if (sel >= 0) begin
                sd                   = data_in[sel*10+8 +: 2];
                s.rd[sel]            = 1'b1;
                s.wr[sd]             = 1'b1;
                s.dout[int'(sd)*10 +: 10] = data_in[sel*10 +: 10];
                s.gid                = 2'(sel);
                s.ld                 = sd;
                s.vg                 = 1'b1;
                s.cnt                = s.cnt + 4'd1;
                nh_in[sel]           = 1'b1;
                nh_d[sd]             = 1'b1;
                if (rr) m_ptr[u] = 2'((sel + 1) % 4);
            end
            m_hin[u]  = nh_in;
            m_hdst[u] = nh_d;
        end
        m_st[u] = s;
        e = s;
    endtask

    task automatic cyc(input int n);
        exp_t e0, e1;
        repeat (n) begin
            model_step(0, 1'b1, e0);
            q0.push_back(e0);
            model_step(1, 1'b0, e1);
            q1.push_back(e1);
            @(posedge clk);
            #1;
            e0 = q0.pop_front();
            chk("rr_rd",   64'(rd0),   64'(e0.rd));
            chk("rr_wr",   64'(wr0),   64'(e0.wr));
            chk("rr_dout", 64'(dout0), 64'(e0.dout));
            chk("rr_gid",  64'(gid0),  64'(e0.gid));
            chk("rr_dest", 64'(ld0),   64'(e0.ld));
            chk("rr_vg",   64'(vg0),   64'(e0.vg));
            chk("rr_cnt",  64'(cnt0),  64'(e0.cnt));
            e1 = q1.pop_front();
            chk("fp_rd",   64'(rd1),   64'(e1.rd));
            chk("fp_wr",   64'(wr1),   64'(e1.wr));
            chk("fp_dout", 64'(dout1), 64'(e1.dout));
            chk("fp_gid",  64'(gid1),  64'(e1.gid));
            chk("fp_dest", 64'(ld1),   64'(e1.ld));
            chk("fp_vg",   64'(vg1),   64'(e1.vg));
            chk("fp_cnt",  64'(cnt1),  64'(e1.cnt));
        end
    endtask

    task automatic fair_heads();
        data_in = {10'h33C, 10'h2C3, 10'h15A, 10'h0A5};
        empty   = 4'b0000;
        full    = 4'b0000;
    endtask

    initial begin
        reset_L = 1'b0;
        fair_heads();
        cyc(2);
        chk("rst_rd",   64'(rd0),   64'd0);
        chk("rst_wr",   64'(wr0),   64'd0);
        chk("rst_dout", 64'(dout0), 64'd0);
        chk("rst_cnt",  64'(cnt0),  64'd0);

        reset_L = 1'b1;
        cyc(1);
        chk("first_rr", 64'(rd0), 64'b0001);
        chk("first_fp", 64'(rd1), 64'b0001);

        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            chk("rr_seq", 64'(gid0), 64'(k % 4));
        end
        chk("rr_head0", 64'(dout0[9:0]), 64'h0A5);

        data_in = {10'h000, 10'h000, 10'h222, 10'h211};
        empty   = 4'b1100;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            chk("hold_wr", 64'(wr0), (k % 2 == 0) ? 64'b0100 : 64'd0);
        end

        data_in = {10'h000, 10'h3AB, 10'h000, 10'h111};
        empty   = 4'b1010;
        full    = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("bp_rd", 64'(rd0), (k % 2 == 0) ? 64'b0100 : 64'd0);
        end
        full = 4'b0000;
        cyc(1);
        chk("bp_release", 64'(rd0), 64'b0001);

        empty = 4'b1111;
        cyc(1);
        data_in = {10'h3CC, 10'h000, 10'h000, 10'h055};
        empty   = 4'b0110;
        cyc(1);
        chk("fp_first", 64'(rd1), 64'b0001);
        cyc(1);
        chk("fp_holdoff", 64'(rd1), 64'b1000);
        cyc(1);
        chk("fp_back", 64'(rd1), 64'b0001);

        for (int k = 0; k < 60; k++) begin
            data_in = 40'({$urandom(), $urandom()});
            empty   = 4'($urandom());
            full    = 4'($urandom()) & 4'($urandom());
            cyc(1);
        end

        reset_L = 1'b0;
        fair_heads();
        cyc(1);
        reset_L = 1'b1;
        cyc(17);
        chk("wrap_rr", 64'(cnt0), 64'd1);
        chk("wrap_fp", 64'(cnt1), 64'd1);

        cyc(1);
        reset_L = 1'b0;
        cyc(1);
        chk("midrst_rd",  64'(rd0),  64'd0);
        chk("midrst_wr",  64'(wr0),  64'd0);
        chk("midrst_cnt", 64'(cnt0), 64'd0);
        chk("midrst_vg",  64'(vg0),  64'd0);
        reset_L = 1'b1;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/arbitro_rr.md
Name: arbitro_rr

Overview:
- Parametrised successor to the 4x4 fixed-priority transaction-layer arbiter.
- Drains N_IN first-word-fall-through input FIFOs and routes each word to one of 2^DEST_W output FIFOs. The destination comes from the word's top DEST_W bits.
- Adds round-robin or fixed-priority selection, output-FIFO backpressure, one-slot pop/push hold-off for registered FIFO handshakes, and a transferred-word counter.
- Sits between the virtual-channel input FIFOs and the destination FIFOs of the transaction layer.

Parameters:
- DATA_W, 10, word width; must be > DEST_W.
- DEST_W, 2, destination field width; field is data[DATA_W-1 -: DEST_W]. N_OUT = 2^DEST_W.
- N_IN, 4, number of input FIFOs (2..16).
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (input 0 highest).
- CNT_W, 16, width of word_count.

Ports:
- clk  in  1  rising-edge clock.
- reset_L  in  1  reset; one clock; reset is synchronous and active-low.
- data_in  in  N_IN*DATA_W  input FIFO heads; input i at [i*DATA_W +: DATA_W].
- empty  in  N_IN  input FIFO empty flags.
- full  in  N_OUT  output FIFO full flags.
- rd  out  N_IN  registered pop strobes, one-hot or zero.
- data_out  out  N_OUT*DATA_W  registered output words; channel d at [d*DATA_W +: DATA_W].
- wr  out  N_OUT  registered push strobes, one-hot or zero.
- grant_id  out  clog2(N_IN)  index of the last granted input.
- last_dest  out  DEST_W  destination of the last granted word.
- valid_grant  out  1  high in the cycle rd/wr are asserted.
- word_count  out  CNT_W  total words transferred.

Behaviour:
- Reset (reset_L low at a rising edge):
  - rd, wr, data_out, grant_id, last_dest, valid_grant, word_count all = 0.
  - Round-robin pointer ptr = 0; hold_in = 0; hold_dest = 0.
  - Takes effect mid-transfer: a pending rd/wr is dropped at that edge.
- Every edge, rd, wr and valid_grant default to 0. At most one grant per cycle.
- Eligibility of input i, with d = dest(data_in[i]): eligible[i] = !empty[i] && !hold_in[i] && !full[d] && !hold_dest[d].
- Hold-off:
  - rd/wr registered at edge E0 are consumed by the FIFOs at E1.
  - So at E1 the granted input and the used destination are masked: hold_in = one-hot(i), hold_dest = one-hot(d).
  - Both masks clear at the next edge unless set again.
  - Consequence: the same input or the same destination can be granted at most every 2nd cycle. Different input and different destination may be granted back to back.
- Selection:
  - RR_MODE=1: first eligible i scanning ptr, ptr+1, ... wrapping modulo N_IN. On grant, ptr <= (i+1) mod N_IN. With no grant, ptr holds.
  - RR_MODE=0: lowest eligible index; ptr unused.
- On grant of input i at an edge:
  - rd[i] <= 1; wr[d] <= 1; data_out channel d <= data_in[i]; other data_out channels hold their value.
  - grant_id <= i; last_dest <= d; valid_grant <= 1.
  - word_count <= word_count + 1, wrapping from 2^CNT_W-1 to 0.
- Latency: one edge from eligible head to rd/wr/data_out.
- full[d] is sampled at the grant edge. A full destination blocks only inputs whose head targets d; other inputs proceed (no head-of-line blocking across inputs).
- No eligible input: no strobes; data_out, grant_id, last_dest hold.
- Simultaneous eligibility of all inputs to one destination: the hold-off makes the grants alternate, every other cycle, in pointer order.

Test Plan:
- Reset: drive reset_L=0 with all inputs non-empty -> every output 0 after the edge. Release -> first grant of input 0 one edge later.
- Round-robin fairness: N_IN=4, all non-empty, heads targeting dests 0,1,2,3 -> grant_id sequence 0,1,2,3,0 with rd one-hot each cycle. wr[d] follows and data_out channel d equals the granted head (e.g. 10'h0A5 from input 0 → dest 0).
- Destination hold-off: inputs 0 and 1 both target dest 2 -> grants alternate 0 and 1 on every 2nd cycle; idle cycles in between with wr=0.
- Backpressure: full[1]=1, input 0 head to dest 1, input 2 head to dest 3 -> input 2 granted, input 0 never popped until full[1] drops; then input 0 is granted one edge later.
- Fixed priority: RR_MODE=0, inputs 0 and 3 non-empty to dests 0 and 3 -> input 0 granted; input 3 granted during input 0's hold-off cycle.
- Counter wrap and mid-operation reset: CNT_W=4, 17 transfers -> word_count = 1. Assert reset_L low on the same edge as a grant -> rd/wr stay 0 and word_count = 0.
